// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC^GHR-indexed saturating counters with an
// init sweep after reset, registered predictions, update bypass and GHR recovery.
module gshare_pht #(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned INIT_CTR = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_index,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_index,
  input  logic              update_taken,
  input  logic              update_mispredict,
  input  logic [HIST_W-1:0] update_ghr,
  output logic [HIST_W-1:0] ghr
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              ready_q, ready_d;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]  pred_index_q, pred_index_d;
  logic [HIST_W-1:0] pred_ghr_q, pred_ghr_d;

  logic [CTR_W-1:0]  table_q [DEPTH];
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_waddr;
  logic [CTR_W-1:0]  tbl_wdata;

  logic [IDX_W-1:0]  lk_idx;
  logic [CTR_W-1:0]  upd_cur;
  logic [CTR_W-1:0]  upd_new;
  logic              lk_taken;
  logic [HIST_W-1:0] ghr_spec;
  logic [HIST_W-1:0] ghr_recover;

  // Hashing, saturating counter update and same-index bypass
  always_comb begin
    lk_idx  = lookup_pc ^ IDX_W'(ghr_q);
    upd_cur = table_q[update_index];
    upd_new = upd_cur;
    if (update_taken) begin
      if (upd_cur != {CTR_W{1'b1}}) upd_new = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - CTR_W'(1);
    end
    if (update_valid && (update_index == lk_idx)) begin
      lk_taken = upd_new[CTR_W-1];
    end else begin
      lk_taken = table_q[lk_idx][CTR_W-1];
    end
    // Truncating cast drops the oldest bit, which also covers HIST_W == 1
    ghr_spec    = HIST_W'({ghr_q, lk_taken});
    ghr_recover = HIST_W'({update_ghr, update_taken});
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ghr_d        = ghr_q;
    ready_d      = ready_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    pred_ghr_d   = pred_ghr_q;
    tbl_we       = 1'b0;
    tbl_waddr    = ptr_q;
    tbl_wdata    = CTR_W'(INIT_CTR);

    case (state_q)
      ST_INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = ptr_q;
        tbl_wdata = CTR_W'(INIT_CTR);
        ptr_d     = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (update_valid) begin
          tbl_we    = 1'b1;
          tbl_waddr = update_index;
          tbl_wdata = upd_new;
        end
        if (lookup_valid) begin
          pred_valid_d = 1'b1;
          pred_taken_d = lk_taken;
          pred_index_d = lk_idx;
          pred_ghr_d   = ghr_q;
          ghr_d        = ghr_spec;
        end
        // Recovery wins over a same-cycle speculative shift
        if (update_valid && update_mispredict) begin
          ghr_d = ghr_recover;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      ghr_q        <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      pred_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ghr_q        <= ghr_d;
      ready_q      <= ready_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  // Counter array has no reset; the sweep defines its contents
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  assign ready      = ready_q;
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_index = pred_index_q;
  assign pred_ghr   = pred_ghr_q;
  assign ghr        = ghr_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboard bench for gshare_pht: directed lookups queue expected predictions,
// a monitor compares them as pred_valid appears.
module tb_gshare_pht;

  logic       clk;
  logic       rst;
  logic       ready;
  logic       lookup_valid;
  logic [7:0] lookup_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [7:0] pred_index;
  logic [7:0] pred_ghr;
  logic       update_valid;
  logic [7:0] update_index;
  logic       update_taken;
  logic       update_mispredict;
  logic [7:0] update_ghr;
  logic [7:0] ghr;

  typedef struct packed {
    logic       taken;
    logic [7:0] index;
    logic [7:0] ghr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gshare_pht #(.IDX_W(8), .CTR_W(2), .HIST_W(8), .INIT_CTR(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .ready             (ready),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .pred_valid        (pred_valid),
    .pred_taken        (pred_taken),
    .pred_index        (pred_index),
    .pred_ghr          (pred_ghr),
    .update_valid      (update_valid),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .update_ghr        (update_ghr),
    .ghr               (ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a negedge, queue the expected prediction
  task automatic step(input logic lv, input logic [7:0] pc,
                      input logic uv, input logic [7:0] uidx, input logic ut,
                      input logic um, input logic [7:0] ughr,
                      input logic et, input logic [7:0] eidx, input logic [7:0] eghr);
    exp_t e;
    lookup_valid      = lv;
    lookup_pc         = pc;
    update_valid      = uv;
    update_index      = uidx;
    update_taken      = ut;
    update_mispredict = um;
    update_ghr        = ughr;
    if (lv) begin
      e.taken = et;
      e.index = eidx;
      e.ghr   = eghr;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic lk(input logic [7:0] pc, input logic et, input logic [7:0] eidx,
                    input logic [7:0] eghr);
    step(1'b1, pc, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, et, eidx, eghr);
  endtask

  task automatic upd(input logic [7:0] idx, input logic t);
    step(1'b0, 8'h00, 1'b1, idx, t, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  // Release reset with junk traffic applied, then check ready timing
  task automatic sweep_and_check(input string tag);
    lookup_valid      = 1'b1;
    lookup_pc         = 8'h12;
    update_valid      = 1'b1;
    update_index      = 8'h12;
    update_taken      = 1'b1;
    update_mispredict = 1'b1;
    update_ghr        = 8'hFF;
    repeat (255) @(posedge clk);
    @(negedge clk);
    chk({tag, " ready low at 255"}, 32'(ready), 32'd0);
    chk({tag, " ghr held in init"}, 32'(ghr), 32'h00);
    @(negedge clk);
    chk({tag, " ready high at 256"}, 32'(ready), 32'd1);
    chk({tag, " ghr after init"}, 32'(ghr), 32'h00);
    idle();
  endtask

  // Monitor: samples just after each posedge and pops one expectation per prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pred_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected pred_valid", 32'(pred_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pred_taken", 32'(pred_taken), 32'(e.taken));
          chk("pred_index", 32'(pred_index), 32'(e.index));
          chk("pred_ghr", 32'(pred_ghr), 32'(e.ghr));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing prediction", 32'(pred_valid), 32'd1);
      end
    end
  end

  initial begin
    rst               = 1'b1;
    lookup_valid      = 1'b0;
    lookup_pc         = 8'h00;
    update_valid      = 1'b0;
    update_index      = 8'h00;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    update_ghr        = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset pred_valid", 32'(pred_valid), 32'd0);
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset pred_index", 32'(pred_index), 32'h00);
    chk("reset pred_ghr", 32'(pred_ghr), 32'h00);
    chk("reset ghr", 32'(ghr), 32'h00);
    rst = 1'b0;
    sweep_and_check("first sweep");

    // First lookup on a freshly swept table
    lk(8'h00, 1'b0, 8'h00, 8'h00);
    idle();
    chk("ghr after not-taken lookup", 32'(ghr), 32'h00);

    // Saturate up at 0x05
    repeat (4) upd(8'h05, 1'b1);
    lk(8'h05, 1'b1, 8'h05, 8'h00);
    idle();
    chk("ghr after taken lookup", 32'(ghr), 32'h01);
    step(1'b0, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("ghr recovered to zero", 32'(ghr), 32'h00);

    // Saturate down at 0x05, then one taken step must land at 1
    repeat (5) upd(8'h05, 1'b0);
    lk(8'h05, 1'b0, 8'h05, 8'h00);
    upd(8'h05, 1'b0);
    upd(8'h05, 1'b1);
    lk(8'h05, 1'b0, 8'h05, 8'h00);
    idle();

    // Speculative history shifting
    lk(8'h01, 1'b0, 8'h01, 8'h00);
    lk(8'h02, 1'b0, 8'h02, 8'h00);
    lk(8'h03, 1'b0, 8'h03, 8'h00);
    idle();
    chk("ghr after 3 not-taken", 32'(ghr), 32'h00);
    upd(8'h12, 1'b1);
    upd(8'h12, 1'b1);
    lk(8'h12, 1'b1, 8'h12, 8'h00);
    chk("ghr after taken 0x12", 32'(ghr), 32'h01);
    lk(8'h13, 1'b1, 8'h12, 8'h01);
    chk("ghr after second taken", 32'(ghr), 32'h03);

    // Recovery in the same cycle as a lookup
    step(1'b1, 8'h20, 1'b1, 8'h30, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h23, 8'h03);
    chk("ghr recovery over shift", 32'(ghr), 32'h4B);

    // Bypass: taken update raises 0x40 from 1 to 2
    step(1'b1, 8'h0B, 1'b1, 8'h40, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 8'h4B);
    chk("ghr after bypass taken", 32'(ghr), 32'h97);
    // Bypass: not-taken update drops 0x30 from 2 to 1
    step(1'b1, 8'hA7, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 8'h97);
    chk("ghr after bypass not-taken", 32'(ghr), 32'h2E);

    // Mispredict flag without update_valid does nothing
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    idle();
    chk("ghr ignores lone mispredict", 32'(ghr), 32'h2E);

    // Reset in RUN, then again mid-sweep
    rst = 1'b1;
    #1;
    chk("async reset ready", 32'(ready), 32'd0);
    chk("async reset ghr", 32'(ghr), 32'h00);
    chk("async reset pred_valid", 32'(pred_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep_and_check("resweep");

    // Every entry is back to the init value
    for (int i = 0; i < 256; i++) begin
      lk(8'(i), 1'b0, 8'(i), 8'h00);
    end
    idle();
    idle();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
